// File: rtl/sel_router_pkg.sv
// sel_router_pkg: shared state type and one-hot helpers for the select router
package sel_router_pkg;
  localparam int MAX_SLAVES = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  function automatic logic onehot_valid(input logic [MAX_SLAVES-1:0] sel);
    return (sel != '0) && ((sel & (sel - MAX_SLAVES'(1))) == '0);
  endfunction
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_SLAVES-1:0] sel);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_SLAVES; i++) if (sel[i]) idx = i[3:0];
    return idx;
  endfunction
endpackage

// File: rtl/sel_router_timeout_ctr.sv
// sel_router_timeout_ctr: saturating wait counter flagging expiry at TIMEOUT_CYC-1
module sel_router_timeout_ctr
  import sel_router_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  // clear wins over count; hold at all-ones so the count never wraps
  always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
  assign expired = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/sel_router_fsm.sv
// sel_router_fsm: registered one-hot master-to-slave router with decode and timeout errors
module sel_router_fsm
  import sel_router_pkg::*;
#(
  parameter int NO_OF_SLAVES = 2,
  parameter int DATA_W       = 8,
  parameter int TIMEOUT_CYC  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NO_OF_SLAVES-1:0]        m_sel,
  input  logic [DATA_W-1:0]              m_data,
  input  logic                           m_valid,
  output logic                           m_ready,
  output logic                           m_err,
  output logic [DATA_W-1:0]              m_rdata,
  output logic                           busy,
  output logic [NO_OF_SLAVES-1:0]        s_sel,
  output logic [DATA_W-1:0]              s_data,
  output logic [NO_OF_SLAVES-1:0]        s_valid,
  input  logic [NO_OF_SLAVES-1:0]        s_ready,
  input  logic [NO_OF_SLAVES*DATA_W-1:0] s_rdata
);
  localparam int IW = NO_OF_SLAVES > 1 ? $clog2(NO_OF_SLAVES) : 1;
  if (NO_OF_SLAVES < 1 || NO_OF_SLAVES > MAX_SLAVES) begin : g_bad_slaves
    $error("sel_router_fsm: NO_OF_SLAVES must be in 1..16");
  end
  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NO_OF_SLAVES-1:0] s_sel_q, s_sel_d, s_valid_q, s_valid_d;
  logic [DATA_W-1:0]       s_data_q, s_data_d, m_rdata_q, m_rdata_d;
  logic                    m_ready_q, m_ready_d, m_err_q, m_err_d;
  logic                    ctr_clr, ctr_en, expired;
  logic                    sel_ready;
  logic [DATA_W-1:0]       sel_rdata;
  logic [MAX_SLAVES-1:0]   sel_ext;
  assign sel_ext = MAX_SLAVES'(m_sel);
  sel_router_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );
  // pick the latched slave's ready and read-data slice
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++)
      if (idx_q == IW'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*DATA_W +: DATA_W];
      end
  end
  // next state and datapath; m_ready trails RESP by one cycle as a registered pulse
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    s_sel_d   = s_sel_q;
    s_data_d  = s_data_q;
    s_valid_d = s_valid_q;
    m_err_d   = m_err_q;
    m_rdata_d = m_rdata_q;
    m_ready_d = state_q == RESP;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    case (state_q)
      IDLE:
        if (m_valid) begin
          if (onehot_valid(sel_ext)) begin
            idx_d     = IW'(onehot_to_idx(sel_ext));
            s_sel_d   = m_sel;
            s_data_d  = m_data;
            s_valid_d = m_sel;
            ctr_clr   = 1'b1;
            state_d   = ACCESS;
          end else begin
            m_err_d   = 1'b1;
            m_rdata_d = '0;
            state_d   = RESP;
          end
        end
      ACCESS:
        if (sel_ready) begin
          m_rdata_d = sel_rdata;
          m_err_d   = 1'b0;
          s_valid_d = '0;
          s_sel_d   = '0;
          state_d   = RESP;
        end else begin
          ctr_en = 1'b1;
          if (expired) begin
            m_rdata_d = '0;
            m_err_d   = 1'b1;
            s_valid_d = '0;
            s_sel_d   = '0;
            state_d   = RESP;
          end
        end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      s_sel_q   <= '0;
      s_data_q  <= '0;
      s_valid_q <= '0;
      m_ready_q <= 1'b0;
      m_err_q   <= 1'b0;
      m_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      s_sel_q   <= s_sel_d;
      s_data_q  <= s_data_d;
      s_valid_q <= s_valid_d;
      m_ready_q <= m_ready_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
    end
  end
  assign m_ready = m_ready_q;
  assign m_err   = m_err_q;
  assign m_rdata = m_rdata_q;
  assign busy    = state_q != IDLE;
  assign s_sel   = s_sel_q;
  assign s_data  = s_data_q;
  assign s_valid = s_valid_q;
endmodule

// File: tb/tb_sel_router_fsm.sv
// tb_sel_router_fsm: directed and random transfers checked against a cycle-count model
module tb_sel_router_fsm;
  localparam int N = 2, W = 8, TMO = 16;
  logic clk = 1'b0, rst_n = 1'b0, m_valid = 1'b0;
  logic [N-1:0] m_sel = '0, s_ready = '0, s_sel, s_valid;
  logic [W-1:0] m_data = '0, m_rdata, s_data;
  logic [N*W-1:0] s_rdata = '0;
  logic m_ready, m_err, busy;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  sel_router_fsm #(.NO_OF_SLAVES(N), .DATA_W(W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .m_sel(m_sel), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_err(m_err), .m_rdata(m_rdata), .busy(busy),
    .s_sel(s_sel), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle(input int n);
    m_valid = 1'b0;
    s_ready = 2'($urandom);
    repeat (n) begin
      @(negedge clk);
      check("idle_m_ready", 32'(m_ready), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_s_valid", 32'(s_valid), 0);
    end
  endtask
  // Model: one-hot select -> s_valid for wt+1 cycles (16 on timeout), m_ready two cycles later;
  // bad select -> no s_valid, m_ready on the second cycle. Cycle n is the n-th cycle after accept.
  task automatic run_txn(input logic [1:0] sel, input logic [7:0] data, input int wt,
                         input logic [7:0] rd, input bit other_hi);
    bit ok, tmo, done;
    int exp_sv, exp_n;
    logic [7:0] exp_rd;
    ok = $onehot(sel);
    tmo = ok && wt >= TMO;
    exp_sv = !ok ? 0 : tmo ? TMO : wt + 1;
    exp_n = exp_sv + 2;
    exp_rd = (ok && !tmo) ? rd : 8'h00;
    done = 1'b0;
    m_sel = sel;
    m_data = data;
    m_valid = 1'b1;
    for (int n = 0; n <= exp_n && !done; n++) begin
      if (n > 0) begin
        @(negedge clk);
        check("s_valid", 32'(s_valid), 32'((ok && n <= exp_sv) ? sel : 2'b00));
        check("s_sel", 32'(s_sel), 32'((ok && n <= exp_sv) ? sel : 2'b00));
        check("busy", 32'(busy), 32'(n < exp_n));
        check("m_ready", 32'(m_ready), 32'(n == exp_n));
        if (n == 1 && ok) check("s_data", 32'(s_data), 32'(data));
        done = m_ready;
        m_sel = 2'($urandom);
        m_data = 8'($urandom);
      end
      s_ready = other_hi ? ~sel : 2'($urandom);
      s_ready = (s_ready & ~sel) | ((ok && n == wt + 1) ? sel : 2'b00);
      s_rdata = 16'($urandom);
      if (ok && n == wt + 1) begin
        if (sel[1]) s_rdata[15:8] = rd;
        else s_rdata[7:0] = rd;
      end
    end
    m_valid = 1'b0;
    check("m_err", 32'(m_err), 32'(!ok || tmo));
    check("m_rdata", 32'(m_rdata), 32'(exp_rd));
  endtask
  initial begin
    logic [1:0] sel;
    int k, wt;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_m_ready", 32'(m_ready), 0);
    check("rst_m_err", 32'(m_err), 0);
    check("rst_m_rdata", 32'(m_rdata), 0);
    check("rst_s_valid", 32'(s_valid), 0);
    check("rst_s_sel", 32'(s_sel), 0);
    check("rst_s_data", 32'(s_data), 0);
    rst_n = 1'b1;
    idle(1);
    run_txn(2'b01, 8'hAB, 0, 8'h5C, 1'b0);
    idle(1);
    run_txn(2'b10, 8'h3C, 5, 8'hE7, 1'b1);
    idle(1);
    run_txn(2'b11, 8'h12, 0, 8'h99, 1'b0);
    idle(1);
    run_txn(2'b00, 8'h34, 0, 8'h99, 1'b1);
    idle(1);
    run_txn(2'b01, 8'h56, 100, 8'h77, 1'b1);
    idle(1);
    run_txn(2'b01, 8'h78, 15, 8'hC3, 1'b0);
    idle(1);
    m_sel = 2'b01;
    m_data = 8'h42;
    m_valid = 1'b1;
    s_ready = 2'b00;
    repeat (3) @(negedge clk);
    check("pre_rst_s_valid", 32'(s_valid), 32'(2'b01));
    rst_n = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_s_valid", 32'(s_valid), 0);
    check("mid_rst_s_sel", 32'(s_sel), 0);
    check("mid_rst_s_data", 32'(s_data), 0);
    check("mid_rst_m_rdata", 32'(m_rdata), 0);
    check("mid_rst_m_ready", 32'(m_ready), 0);
    rst_n = 1'b1;
    idle(4);
    run_txn(2'b10, 8'h9A, 2, 8'h3E, 1'b0);
    idle(1);
    run_txn(2'b01, 8'h11, 1, 8'hA1, 1'b0);
    run_txn(2'b10, 8'h22, 2, 8'hB2, 1'b0);
    idle(2);
    repeat (40) begin
      k = $urandom_range(0, 9);
      sel = ($urandom_range(0, 3) == 0) ? 2'($urandom) : ($urandom_range(0, 1) == 1 ? 2'b10 : 2'b01);
      wt = k < 7 ? $urandom_range(0, 6) : k < 9 ? $urandom_range(14, 17) : 30;
      run_txn(sel, 8'($urandom), wt, 8'($urandom), 1'($urandom));
      idle($urandom_range(0, 2));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
